// File: rtl/dpmu_multicore.sv
// Multi-core DVFS controller: filtered global mode selection plus
// per-core voltage/frequency ramping in a safe step order.
module dpmu_multicore #(
    parameter int NCORES    = 4,
    parameter int VW        = 2,
    parameter int FW        = 3,
    parameter int DWELL     = 8,
    parameter int STEP_WAIT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 perf_req,
    input  logic [1:0]           temp_sensor,
    input  logic [1:0]           battery_level,
    input  logic [NCORES-1:0]    core_busy,
    output logic [NCORES*VW-1:0] vlevel,
    output logic [NCORES*FW-1:0] flevel,
    output logic [2:0]           mode,
    output logic                 power_save,
    output logic                 busy
);

    typedef enum logic [2:0] {
        M_NORMAL  = 3'd0,
        M_PERF    = 3'd1,
        M_PSAVE   = 3'd2,
        M_THERMAL = 3'd3,
        M_BATT    = 3'd4
    } mode_e;

    localparam logic [VW-1:0] VMAX = '1;
    localparam logic [FW-1:0] FMAX = '1;
    localparam int CW = $clog2(DWELL + 1);
    localparam int TW = (STEP_WAIT > 1) ? $clog2(STEP_WAIT) : 1;
    localparam logic [CW-1:0] DW    = CW'(DWELL);
    localparam logic [TW-1:0] TLOAD = TW'(STEP_WAIT - 1);

    mode_e          mode_q, mode_d;
    mode_e          cand, cand_q;
    logic [CW-1:0]  cnt_q, cnt_d, cnt_n;
    logic           safety;
    logic [NCORES-1:0] off;

    always_comb begin
        if (battery_level <= 2'd1)
            cand = M_BATT;
        else if (temp_sensor >= 2'd2)
            cand = M_THERMAL;
        else if (perf_req)
            cand = M_PERF;
        else if (core_busy == '0)
            cand = M_PSAVE;
        else
            cand = M_NORMAL;
    end

    assign safety = (cand == M_BATT) || (cand == M_THERMAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= M_NORMAL;
            cand_q <= M_NORMAL;
            cnt_q  <= '0;
        end else begin
            mode_q <= mode_d;
            cand_q <= cand;
            cnt_q  <= cnt_d;
        end
    end

    // Safety modes bypass the dwell filter entirely.
    always_comb begin
        mode_d = mode_q;
        cnt_d  = '0;
        cnt_n  = (cand == cand_q) ? cnt_q + CW'(1) : CW'(1);
        if (cand != mode_q) begin
            if (safety)
                mode_d = cand;
            else if (cnt_n == DW)
                mode_d = cand;
            else
                cnt_d = cnt_n;
        end
    end

    always_comb begin
        mode       = mode_q;
        power_save = (mode_q == M_PSAVE) || (mode_q == M_BATT);
    end

    for (genvar i = 0; i < NCORES; i++) begin : g_core
        logic [VW-1:0] v_q, v_d, tv;
        logic [FW-1:0] f_q, f_d, tf;
        logic [TW-1:0] t_q, t_d;

        always_comb begin
            tv = '0;
            tf = '0;
            case (mode_q)
                M_PERF: begin
                    tv = VMAX;
                    tf = FMAX;
                end
                M_NORMAL: begin
                    tv = VMAX >> 1;
                    tf = core_busy[i] ? (FMAX >> 1) : '0;
                end
                M_THERMAL: begin
                    tv = VMAX >> 1;
                    tf = FMAX >> 2;
                end
                M_PSAVE: begin
                    tv = '0;
                    tf = FW'(1);
                end
                default: begin
                    tv = '0;
                    tf = '0;
                end
            endcase
        end

        assign off[i] = (v_q != tv) || (f_q != tf);

        // Frequency leaves before voltage drops; voltage arrives before
        // frequency rises.
        always_comb begin
            v_d = v_q;
            f_d = f_q;
            t_d = t_q;
            if (t_q != '0) begin
                t_d = t_q - TW'(1);
            end else if (off[i]) begin
                t_d = TLOAD;
                if (f_q > tf)
                    f_d = f_q - FW'(1);
                else if (v_q < tv)
                    v_d = v_q + VW'(1);
                else if (f_q < tf)
                    f_d = f_q + FW'(1);
                else
                    v_d = v_q - VW'(1);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= '0;
                f_q <= '0;
                t_q <= '0;
            end else begin
                v_q <= v_d;
                f_q <= f_d;
                t_q <= t_d;
            end
        end

        assign vlevel[i*VW +: VW] = v_q;
        assign flevel[i*FW +: FW] = f_q;
    end

    assign busy = |off;

endmodule

// File: tb/tb_dpmu_multicore.sv
// Directed bench for dpmu_multicore at default parameters:
// reset, NORMAL/PERF/THERMAL/BATTERY/POWERSAVE ramps, dwell glitch.
module tb_dpmu_multicore;

    logic        clk;
    logic        rst_n;
    logic        perf_req;
    logic [1:0]  temp_sensor;
    logic [1:0]  battery_level;
    logic [3:0]  core_busy;
    logic [7:0]  vlevel;
    logic [11:0] flevel;
    logic [2:0]  mode;
    logic        power_save;
    logic        busy;

    int checks;
    int errors;

    dpmu_multicore dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .perf_req      (perf_req),
        .temp_sensor   (temp_sensor),
        .battery_level (battery_level),
        .core_busy     (core_busy),
        .vlevel        (vlevel),
        .flevel        (flevel),
        .mode          (mode),
        .power_save    (power_save),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        perf_req      = 1'b0;
        temp_sensor   = 2'd0;
        battery_level = 2'd3;
        core_busy     = 4'hF;
        rst_n         = 1'b0;
        tick(2);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (vlevel !== 8'h00 || flevel !== 12'h000) begin
            errors++;
            $display("FAIL reset_levels v=%h f=%h exp v=00 f=000", vlevel, flevel);
        end
        checks++;
        if (mode !== 3'd0 || power_save !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_flags mode=%0d ps=%b busy=%b exp 0 0 1", mode, power_save, busy);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_normal_ramp();
        tick(1);
        checks++;
        if (vlevel !== 8'h55 || flevel !== 12'h000) begin
            errors++;
            $display("FAIL normal_e1 v=%h f=%h exp v=55 f=000", vlevel, flevel);
        end
        tick(3);
        checks++;
        if (flevel !== 12'h000) begin
            errors++;
            $display("FAIL normal_e4_wait f=%h exp 000", flevel);
        end
        tick(1);
        checks++;
        if (flevel !== 12'h249) begin
            errors++;
            $display("FAIL normal_e5 f=%h exp 249", flevel);
        end
        tick(4);
        checks++;
        if (flevel !== 12'h492) begin
            errors++;
            $display("FAIL normal_e9 f=%h exp 492", flevel);
        end
        tick(3);
        checks++;
        if (busy !== 1'b1 || flevel !== 12'h492) begin
            errors++;
            $display("FAIL normal_e12 busy=%b f=%h exp 1 492", busy, flevel);
        end
        tick(1);
        checks++;
        if (flevel !== 12'h6DB || vlevel !== 8'h55 || busy !== 1'b0 || mode !== 3'd0) begin
            errors++;
            $display("FAIL normal_e13 f=%h v=%h busy=%b mode=%0d exp 6db 55 0 0",
                     flevel, vlevel, busy, mode);
        end
    endtask

    task automatic test_perf();
        tick(3);
        perf_req = 1'b1;
        tick(7);
        checks++;
        if (mode !== 3'd0) begin
            errors++;
            $display("FAIL perf_dwell7 mode=%0d exp 0", mode);
        end
        tick(1);
        checks++;
        if (mode !== 3'd1 || vlevel !== 8'h55) begin
            errors++;
            $display("FAIL perf_commit mode=%0d v=%h exp 1 55", mode, vlevel);
        end
        tick(1);
        checks++;
        if (vlevel !== 8'hAA || flevel !== 12'h6DB) begin
            errors++;
            $display("FAIL perf_v2 v=%h f=%h exp aa 6db", vlevel, flevel);
        end
        tick(4);
        checks++;
        if (vlevel !== 8'hFF) begin
            errors++;
            $display("FAIL perf_v3 v=%h exp ff", vlevel);
        end
        tick(4);
        checks++;
        if (flevel !== 12'h924) begin
            errors++;
            $display("FAIL perf_f4 f=%h exp 924", flevel);
        end
        tick(8);
        checks++;
        if (flevel !== 12'hDB6 || busy !== 1'b1) begin
            errors++;
            $display("FAIL perf_f6 f=%h busy=%b exp db6 1", flevel, busy);
        end
        tick(4);
        checks++;
        if (flevel !== 12'hFFF || busy !== 1'b0 || power_save !== 1'b0) begin
            errors++;
            $display("FAIL perf_f7 f=%h busy=%b ps=%b exp fff 0 0", flevel, busy, power_save);
        end
    endtask

    task automatic test_thermal();
        tick(3);
        temp_sensor = 2'd3;
        tick(1);
        checks++;
        if (mode !== 3'd3 || flevel !== 12'hFFF) begin
            errors++;
            $display("FAIL thermal_entry mode=%0d f=%h exp 3 fff", mode, flevel);
        end
        tick(1);
        checks++;
        if (flevel !== 12'hDB6 || vlevel !== 8'hFF) begin
            errors++;
            $display("FAIL thermal_f6 f=%h v=%h exp db6 ff", flevel, vlevel);
        end
        tick(16);
        checks++;
        if (flevel !== 12'h492 || vlevel !== 8'hFF) begin
            errors++;
            $display("FAIL thermal_f2 f=%h v=%h exp 492 ff", flevel, vlevel);
        end
        tick(4);
        checks++;
        if (flevel !== 12'h249 || vlevel !== 8'hFF) begin
            errors++;
            $display("FAIL thermal_f1 f=%h v=%h exp 249 ff", flevel, vlevel);
        end
        tick(4);
        checks++;
        if (vlevel !== 8'hAA) begin
            errors++;
            $display("FAIL thermal_v2 v=%h exp aa", vlevel);
        end
        tick(4);
        checks++;
        if (vlevel !== 8'h55 || busy !== 1'b0) begin
            errors++;
            $display("FAIL thermal_v1 v=%h busy=%b exp 55 0", vlevel, busy);
        end
    endtask

    task automatic test_battery();
        tick(3);
        battery_level = 2'd0;
        tick(1);
        checks++;
        if (mode !== 3'd4 || power_save !== 1'b1 || flevel !== 12'h249) begin
            errors++;
            $display("FAIL battery_entry mode=%0d ps=%b f=%h exp 4 1 249", mode, power_save, flevel);
        end
        tick(1);
        checks++;
        if (flevel !== 12'h000 || vlevel !== 8'h55) begin
            errors++;
            $display("FAIL battery_f0 f=%h v=%h exp 000 55", flevel, vlevel);
        end
        tick(4);
        checks++;
        if (vlevel !== 8'h00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL battery_v0 v=%h busy=%b exp 00 0", vlevel, busy);
        end
    endtask

    task automatic test_idle_cores();
        do_reset();
        rst_n = 1'b1;
        tick(16);
        core_busy = 4'b0010;
        tick(1);
        checks++;
        if (flevel !== 12'h49A) begin
            errors++;
            $display("FAIL idle_first f=%h exp 49a", flevel);
        end
        tick(8);
        checks++;
        if (flevel !== 12'h018 || vlevel !== 8'h55 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_settled f=%h v=%h busy=%b exp 018 55 0", flevel, vlevel, busy);
        end
        core_busy = 4'b0000;
        tick(7);
        checks++;
        if (mode !== 3'd0 || flevel !== 12'h008) begin
            errors++;
            $display("FAIL psave_dwell7 mode=%0d f=%h exp 0 008", mode, flevel);
        end
        tick(1);
        checks++;
        if (mode !== 3'd2 || power_save !== 1'b1) begin
            errors++;
            $display("FAIL psave_commit mode=%0d ps=%b exp 2 1", mode, power_save);
        end
        tick(1);
        checks++;
        if (flevel !== 12'h249 || vlevel !== 8'h51) begin
            errors++;
            $display("FAIL psave_step1 f=%h v=%h exp 249 51", flevel, vlevel);
        end
        tick(4);
        checks++;
        if (flevel !== 12'h249 || vlevel !== 8'h00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL psave_final f=%h v=%h busy=%b exp 249 00 0", flevel, vlevel, busy);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        rst_n = 1'b1;
        tick(16);
        perf_req = 1'b1;
        tick(5);
        perf_req = 1'b0;
        tick(1);
        perf_req = 1'b1;
        tick(7);
        checks++;
        if (mode !== 3'd0) begin
            errors++;
            $display("FAIL glitch_no_commit mode=%0d exp 0", mode);
        end
        tick(1);
        checks++;
        if (mode !== 3'd1) begin
            errors++;
            $display("FAIL glitch_commit mode=%0d exp 1", mode);
        end
    endtask

    task automatic test_reset_midramp();
        tick(1);
        checks++;
        if (vlevel !== 8'hAA) begin
            errors++;
            $display("FAIL midramp_pre v=%h exp aa", vlevel);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (vlevel !== 8'h00 || flevel !== 12'h000 || mode !== 3'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midramp_reset v=%h f=%h mode=%0d busy=%b exp 00 000 0 1",
                     vlevel, flevel, mode, busy);
        end
        perf_req = 1'b0;
        tick(1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_normal_ramp();
        test_perf();
        test_thermal();
        test_battery();
        test_idle_cores();
        test_glitch();
        test_reset_midramp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dpmu_multicore.md
# dpmu_multicore

Parametrised multi-core dynamic power management unit. It chooses one global operating mode from the performance request, temperature, battery and per-core activity inputs. Mode changes are filtered by a dwell counter, except for safety entries, which take effect immediately. Each core's voltage/frequency pair then ramps toward the mode target one level at a time, in a safe order. The block sits between the sensor inputs and the per-core regulator/clock-divider controls and replaces the fixed three-domain controller.

## Interface
- NCORES, 4, number of core domains (1..8)
- VW, 2, voltage level width; VMAX = 2^VW-1
- FW, 3, frequency level width; FMAX = 2^FW-1
- DWELL, 8, consecutive cycles a non-safety mode request must persist before commit (>=1)
- STEP_WAIT, 4, minimum cycles between successive level steps of one core (>=1)

Ports:
- clk  in  1  clock; all state updates on rising edge only
- rst_n  in  1  asynchronous active-low reset
- perf_req  in  1  performance mode request
- temp_sensor  in  2  temperature code; >=2 means hot
- battery_level  in  2  battery code; <=1 means low
- core_busy  in  NCORES  per-core activity, 1 = busy
- vlevel  out  NCORES*VW  per-core voltage level, core i at [i*VW +: VW]
- flevel  out  NCORES*FW  per-core frequency level, core i at [i*FW +: FW]
- mode  out  3  committed mode: 0 NORMAL, 1 PERFORMANCE, 2 POWERSAVE, 3 THERMAL, 4 BATTERY
- power_save  out  1  high when mode is POWERSAVE or BATTERY
- busy  out  1  high while any core is off its target

## Operation
- Candidate mode is evaluated every cycle, in priority order:
  - battery_level<=1 -> BATTERY
  - else temp_sensor>=2 -> THERMAL
  - else perf_req -> PERFORMANCE
  - else core_busy==0 -> POWERSAVE
  - else NORMAL
- Safety commit: a candidate of BATTERY or THERMAL that differs from mode commits at the next edge, and the dwell counter clears.
- Dwell commit, for any other candidate different from mode:
  - the dwell counter increments while the candidate is unchanged from the previous cycle;
  - it restarts at 1 when the candidate changes;
  - mode commits on the edge where the count reaches DWELL, and the counter clears.
  - If the candidate equals mode, the counter clears.
- Per-core targets (tv, tf):
  - PERFORMANCE: VMAX, FMAX
  - NORMAL: VMAX>>1, FMAX>>1; a core with core_busy=0 gets tf=0
  - THERMAL: VMAX>>1, FMAX>>2
  - POWERSAVE: 0, 1
  - BATTERY: 0, 0
- Per-core ramp engine: each core has its own step timer. At an edge where the timer is 0 and the core is off target, exactly one step is taken, chosen in this priority:
  1. f>tf: f-1
  2. else v<tv: v+1
  3. else f<tf: f+1
  4. else v>tv: v-1
- Ordering rules that follow from this:
  - voltage never drops while frequency is above target;
  - frequency never rises while voltage is below target.
- After a step the timer loads STEP_WAIT-1. Otherwise it decrements while nonzero.
- Targets follow mode combinationally. A target change mid-ramp redirects the next step; it does not reload or cancel a running timer.
- busy = OR over cores of (v!=tv or f!=tf).

## Timing
- Reset values (asynchronous, immediate):
  - mode=NORMAL, every vlevel=0, every flevel=0
  - timers=0, dwell counter=0
  - power_save=0, busy=1 (cores are below NORMAL targets)
- After reset release, the first ramp step occurs on the first rising edge.
- Safety entry: an input sampled at edge k gives a new mode at edge k, and the first step toward the new target at edge k+1 if that core's timer is 0.
- Non-safety entry: mode changes on the DWELL-th consecutive edge of the stable candidate.
- A one-cycle glitch of the candidate restarts the dwell count.
- Reset asserted mid-ramp forces all levels to 0 at once; no ramp-down sequence.
- Levels never wrap: steps occur only when off target, and targets lie within 0..VMAX / 0..FMAX.
- Simultaneous hot and low-battery: BATTERY wins.
- Outputs are registered; there is no combinational path from any input to vlevel, flevel or power_save. mode is also registered.

## Test plan
Defaults used: NCORES=4, VW=2, FW=3, DWELL=8, STEP_WAIT=4.
- Reset release with all cores busy, nominal sensors:
  - each core steps v0->1, then f1, f2, f3, on edges 1, 5, 9, 13;
  - busy falls after edge 13; mode=0.
- perf_req high for 8 cycles from settled NORMAL:
  - mode=1 on the 8th edge;
  - each core goes v2, v3, then f4..f7, steps 4 cycles apart; busy clears after 6 steps.
- perf_req high for 5 cycles, low for 1, high for 8:
  - no commit until the 8th cycle of the second high run.
- temp_sensor=3 while in PERFORMANCE:
  - mode=3 at the next edge;
  - f steps down 7->1 first, then v 3->1; v never drops while f>1.
- temp_sensor=3 and battery_level=0 together:
  - mode=4 at the next edge, power_save=1;
  - each core ramps f to 0, then v to 0.
- NORMAL with core_busy=4'b0010:
  - idle cores ramp f to 0 while core 1 stays at v1/f3;
  - after core_busy=0 for 8 cycles, mode=2 and all cores reach v0/f1.
